// File: rtl/wb_regfile_pkg.sv
// Shared types and sizing for the integer register file and its pending-load scoreboard.
package wb_regfile_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xdata_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback, ID read-port and load-issue signals between the pipeline (master) and the register file (slave).
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic      wb_we;
  reg_addr_t wb_wa;
  xdata_t    wb_wn;
  logic      re1;
  reg_addr_t ra1;
  xdata_t    rn1;
  logic      re2;
  reg_addr_t ra2;
  xdata_t    rn2;
  logic      iss_ld;
  reg_addr_t iss_wa;
  logic      flush;
  logic      stl_req;

  modport master (
    output wb_we, wb_wa, wb_wn,
    output re1, ra1, re2, ra2,
    output iss_ld, iss_wa, flush,
    input  rn1, rn2, stl_req
  );

  modport slave (
    input  wb_we, wb_wa, wb_wn,
    input  re1, ra1, re2, ra2,
    input  iss_ld, iss_wa, flush,
    output rn1, rn2, stl_req
  );

endinterface

// File: rtl/wb_regfile_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set on load issue, cleared at writeback or flush.
module reg_scoreboard
  import wb_regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  logic      flush,
  input  reg_addr_t rd_addr1,
  input  reg_addr_t rd_addr2,
  output logic      busy1,
  output logic      busy2
);

  logic [NREG-1:0] busy;

  // Set is applied after clear so a new load to the same register stays in flight.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy <= '0;
    end else begin
      if (clr_en)
        busy[clr_addr] <= 1'b0;
      if (set_en && set_addr != REG_ZERO)
        busy[set_addr] <= 1'b1;
    end
  end

  assign busy1 = (rd_addr1 != REG_ZERO) && busy[rd_addr1];
  assign busy2 = (rd_addr2 != REG_ZERO) && busy[rd_addr2];

endmodule

// File: rtl/wb_regfile.sv
// Integer register file with two combinational read ports, x0 hardwired to zero and load-use stall request.
// Optional REGFILE_BYPASS_EN: forward same-cycle writeback data to reads instead of stalling one cycle.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  xdata_t regs [NREG];
  xdata_t rn1_d;
  xdata_t rn2_d;
  logic   busy1;
  logic   busy2;
  logic   hit1;
  logic   hit2;
  logic   stall1;
  logic   stall2;

  // Storage is intentionally left out of reset; only x0 writes are dropped.
  always_ff @(posedge clk) begin
    if (!rst && bus.wb_we && bus.wb_wa != REG_ZERO)
      regs[bus.wb_wa] <= bus.wb_wn;
  end

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (bus.iss_ld),
    .set_addr (bus.iss_wa),
    .clr_en   (bus.wb_we),
    .clr_addr (bus.wb_wa),
    .flush    (bus.flush),
    .rd_addr1 (bus.ra1),
    .rd_addr2 (bus.ra2),
    .busy1    (busy1),
    .busy2    (busy2)
  );

  assign hit1 = bus.wb_we && (bus.wb_wa == bus.ra1) && (bus.ra1 != REG_ZERO);
  assign hit2 = bus.wb_we && (bus.wb_wa == bus.ra2) && (bus.ra2 != REG_ZERO);

  always_comb begin
    rn1_d = '0;
    rn2_d = '0;
    if (!rst && bus.re1 && bus.ra1 != REG_ZERO) begin
`ifdef REGFILE_BYPASS_EN
      rn1_d = hit1 ? bus.wb_wn : regs[bus.ra1];
`else
      rn1_d = regs[bus.ra1];
`endif
    end
    if (!rst && bus.re2 && bus.ra2 != REG_ZERO) begin
`ifdef REGFILE_BYPASS_EN
      rn2_d = hit2 ? bus.wb_wn : regs[bus.ra2];
`else
      rn2_d = regs[bus.ra2];
`endif
    end
  end

  // Without forwarding, a read racing its own writeback must retry once the array has committed.
`ifdef REGFILE_BYPASS_EN
  assign stall1 = bus.re1 && busy1 && !hit1;
  assign stall2 = bus.re2 && busy2 && !hit2;
`else
  assign stall1 = bus.re1 && (busy1 || hit1);
  assign stall2 = bus.re2 && (busy2 || hit2);
`endif

  assign bus.rn1     = rn1_d;
  assign bus.rn2     = rn2_d;
  assign bus.stl_req = !rst && (stall1 || stall2);

endmodule
